wb_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the integer register file among several writeback requesters (ALU, LSU, CSR unit). Each requester issues a valid/ready write request. The block grants one request per cycle and registers the winning address/data into a one-entry output stage. That stage drives the write enable of the register file's enable-gated flip-flop banks. x0 writes are filtered, and an optional forwarding path exposes the in-flight write to read ports.

---
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the integer register-file write port, with a one-entry output stage.
// Optional forwarding of the in-flight write is enabled by defining WB_ARB_FORWARD_EN.
module wb_port_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = 5,
   parameter int DATA_LEN = 64,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
   input  logic                         wb_hold,
   output logic                         rf_wen,
   output logic [ADDR_W-1:0]            rf_waddr,
   output logic [DATA_LEN-1:0]          rf_wdata,
   output logic [ID_W-1:0]              grant_id,
   input  logic [ADDR_W-1:0]            fwd_raddr,
   output logic                         fwd_hit,
   output logic [DATA_LEN-1:0]          fwd_data
);

   logic [ID_W-1:0]     rr_ptr;
   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
   logic [DATA_LEN-1:0] data_arr [NUM_REQ];

   logic                gnt_vld_p0;
   logic [ID_W-1:0]     gnt_id_p0;
   logic [ADDR_W-1:0]   gnt_addr_p0;
   logic [DATA_LEN-1:0] gnt_data_p0;
   logic [NUM_REQ-1:0]  ready_p0;

   logic                vld_p1;
   logic [ADDR_W-1:0]   waddr_p1;
   logic [DATA_LEN-1:0] wdata_p1;
   logic [ID_W-1:0]     gid_p1;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
         data_arr[i] = req_data[i*DATA_LEN +: DATA_LEN];
      end
   end

   // Stage p0: combinational grant, scanning from rr_ptr with wrap at NUM_REQ
   always_comb begin
      int          idx;
      logic [ID_W-1:0] idx_t;
      gnt_vld_p0  = 1'b0;
      gnt_id_p0   = '0;
      gnt_addr_p0 = '0;
      gnt_data_p0 = '0;
      ready_p0    = '0;
      idx         = 0;
      idx_t       = '0;
      if (rst_n && !wb_hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_t = ID_W'(idx);
            if (!gnt_vld_p0 && req_valid[idx_t]) begin
               gnt_vld_p0  = 1'b1;
               gnt_id_p0   = idx_t;
               gnt_addr_p0 = addr_arr[idx_t];
               gnt_data_p0 = data_arr[idx_t];
            end
         end
      end
      if (gnt_vld_p0) ready_p0 = NUM_REQ'(1) << gnt_id_p0;
   end

   assign req_ready = ready_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (gnt_vld_p0) begin
         rr_ptr <= (gnt_id_p0 == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_p0 + 1'b1;
      end
   end

   // Stage p1: registered write port; x0 writes are accepted but never enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         waddr_p1 <= '0;
         wdata_p1 <= '0;
         gid_p1   <= '0;
      end else begin
         vld_p1 <= gnt_vld_p0 && (gnt_addr_p0 != '0);
         if (gnt_vld_p0) begin
            waddr_p1 <= gnt_addr_p0;
            wdata_p1 <= gnt_data_p0;
            gid_p1   <= gnt_id_p0;
         end
      end
   end

   assign rf_wen   = vld_p1;
   assign rf_waddr = waddr_p1;
   assign rf_wdata = wdata_p1;
   assign grant_id = gid_p1;

`ifdef WB_ARB_FORWARD_EN
   assign fwd_hit  = vld_p1 && (waddr_p1 == fwd_raddr);
   assign fwd_data = wdata_p1;
`else
   logic fwd_unused;
   assign fwd_unused = ^fwd_raddr;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_port_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 64;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic            wb_hold;
   logic            rf_wen;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic [IW-1:0]   grant_id;
   logic [AW-1:0]   fwd_raddr;
   logic            fwd_hit;
   logic [DW-1:0]   fwd_data;

   wb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_LEN(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .wb_hold(wb_hold),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: priority pointer plus the expected registered write
   int            m_ptr;
   int            m_gnt;
   logic          m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   int            m_gid;

   logic          pend [N];
   logic [AW-1:0] pa   [N];
   logic [DW-1:0] pd   [N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (!rst_n || wb_hold) return -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0; m_gnt = -1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // One clock: compare all outputs at the falling edge, then advance the model at the rising edge
   task automatic step();
      logic [N-1:0] exp_ready;
      logic         exp_hit;
      logic [DW-1:0] exp_fd;
      @(negedge clk);
      m_gnt = model_grant();
      exp_ready = (m_gnt >= 0) ? N'(1 << m_gnt) : '0;
`ifdef WB_ARB_FORWARD_EN
      exp_hit = m_wen && (m_waddr == fwd_raddr);
      exp_fd  = m_wdata;
`else
      exp_hit = 1'b0;
      exp_fd  = '0;
`endif
      chk("req_ready", req_ready, exp_ready);
      chk("rf_wen",    rf_wen,    m_wen);
      chk("rf_waddr",  rf_waddr,  m_waddr);
      chk("rf_wdata",  rf_wdata,  m_wdata);
      chk("grant_id",  grant_id,  m_gid);
      chk("fwd_hit",   fwd_hit,   exp_hit);
      chk("fwd_data",  fwd_data,  exp_fd);
      @(posedge clk);
      if (rst_n) begin
         if (m_gnt >= 0) begin
            m_waddr = req_addr[m_gnt*AW +: AW];
            m_wdata = req_data[m_gnt*DW +: DW];
            m_gid   = m_gnt;
            m_wen   = (m_waddr != 0);
            m_ptr   = (m_gnt + 1) % N;
         end else begin
            m_wen = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; wb_hold = 1'b0; fwd_raddr = '0;
      req_valid = '0; req_addr = '0; req_data = '0;
      model_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(100 + i));

      // Reset with everyone requesting
      #2;
      chk("rst_ready", req_ready, 0);
      chk("rst_wen",   rf_wen,    0);
      chk("rst_waddr", rf_waddr,  0);
      chk("rst_wdata", rf_wdata,  0);
      step(); step();
      rst_n = 1'b1;
      #1 chk("rst_first_gnt", req_ready, 3'b001);

      // Full contention: grants rotate 0,1,2,...
      for (int c = 0; c < 6; c++) begin
         #1 chk("cont_gnt", req_ready, 64'(1 << (c % 3)));
         step();
         chk("cont_wen",   rf_wen,   1);
         chk("cont_waddr", rf_waddr, 64'(c % 3 + 1));
      end

      // Pointer skip: rr_ptr=1, only requester 0 valid
      set_req(0, 1'b1, 5, 64'hAA); set_req(1, 1'b0, 0, 0); set_req(2, 1'b0, 0, 0);
      step();
      #1 chk("skip_gnt", req_ready, 3'b001);
      step();
      chk("skip_wen",   rf_wen,   1);
      chk("skip_waddr", rf_waddr, 5);
      chk("skip_wdata", rf_wdata, 64'hAA);
      chk("skip_gid",   grant_id, 0);
      set_req(1, 1'b1, 9, 64'h99);
      #1 chk("skip_ptr", req_ready, 3'b010);
      step();
      set_req(0, 1'b0, 0, 0); set_req(1, 1'b0, 0, 0);

      // x0 filter
      set_req(2, 1'b1, 0, 64'h55);
      #1 chk("x0_ready", req_ready, 3'b100);
      step();
      chk("x0_wen",   rf_wen,   0);
      chk("x0_gid",   grant_id, 2);
      chk("x0_waddr", rf_waddr, 0);
      chk("x0_wdata", rf_wdata, 64'h55);
      set_req(2, 1'b0, 0, 0);

      // Hold freezes arbitration and the pointer
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(200 + i));
      wb_hold = 1'b1;
      #1 chk("hold_ready", req_ready, 0);
      step();
      chk("hold_wen", rf_wen, 0);
      wb_hold = 1'b0;
      #1 chk("hold_ptr", req_ready, 3'b001);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);

      // Forwarding window, then asynchronous reset between edges
      set_req(1, 1'b1, 7, 64'h1234);
      step();
      set_req(1, 1'b0, 0, 0);
      fwd_raddr = 7;
      #1;
`ifdef WB_ARB_FORWARD_EN
      chk("fwd_hit_lit",  fwd_hit,  1);
      chk("fwd_data_lit", fwd_data, 64'h1234);
`else
      chk("fwd_hit_lit",  fwd_hit,  0);
      chk("fwd_data_lit", fwd_data, 0);
`endif
      chk("async_pre_wen", rf_wen, 1);
      rst_n = 1'b0;
      #1;
      chk("async_wen",   rf_wen,   0);
      chk("async_waddr", rf_waddr, 0);
      chk("async_wdata", rf_wdata, 0);
      chk("async_gid",   grant_id, 0);
      chk("async_fwd",   fwd_hit,  0);
      model_reset();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 10), DW'(300 + i));
      #1 chk("async_restart", req_ready, 3'b001);
      step();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);

      // Randomized traffic; requesters hold valid/addr/data until their transfer
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6) begin
               pend[i] = 1'b1;
               pa[i]   = AW'($urandom_range(0, 31));
               pd[i]   = {$urandom, $urandom};
            end
            set_req(i, pend[i], pa[i], pd[i]);
         end
         wb_hold   = ($urandom_range(0, 7) == 0);
         fwd_raddr = ($urandom_range(0, 1) == 1) ? m_waddr : AW'($urandom_range(0, 31));
         step();
         if (m_gnt >= 0) pend[m_gnt] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
